fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit.sv | 123 ++++++++++++
 tb/tb_fetch_unit.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction fetch sequencer: fetches one word per instruction, holds it for
// the datapath, and computes the next PC from jump/branch/jr redirects.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          XLEN     = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_ack,
    input  logic [XLEN-1:0] imem_rdata,
    input  logic            imem_err,
    output logic [XLEN-1:0] instr,
    output logic [5:0]      op,
    output logic [5:0]      funct,
    output logic            instr_valid,
    output logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] pc_plus4,
    input  logic            exec_done,
    input  logic [1:0]      branch,
    input  logic            zero,
    input  logic            jump,
    input  logic            jump_reg,
    input  logic [XLEN-1:0] reg_target,
    output logic            halted,
    output logic [XLEN-1:0] retired
);

    typedef enum logic [1:0] {IDLE, FETCH, EXEC, HALT} state_t;

    state_t          state, state_nxt;
    logic            take_fetch;
    logic            take_exec;
    logic            pc_fault;
    logic            br_taken;
    logic [XLEN-1:0] next_pc;

    function automatic logic [XLEN-1:0] branch_target(input logic [XLEN-1:0] base,
                                                      input logic [15:0]     imm);
        logic signed [XLEN-1:0] off;
        off = XLEN'($signed(imm)) <<< 2;
        return base + $unsigned(off);
    endfunction

    function automatic logic [XLEN-1:0] jump_target(input logic [XLEN-1:0] base,
                                                    input logic [XLEN-1:0] word);
        return {base[31:28], word[25:0], 2'b00};
    endfunction

    assign pc_plus4 = pc + XLEN'(4);
    assign br_taken = (branch == 2'b01 && zero) || (branch == 2'b11 && !zero);
    // jr to a non-word-aligned target is a fault rather than a redirect
    assign pc_fault = jump_reg && (reg_target[1:0] != 2'b00);

    always_comb begin
        next_pc = pc_plus4;
        if (jump_reg)
            next_pc = reg_target;
        else if (jump)
            next_pc = jump_target(pc_plus4, instr);
        else if (br_taken)
            next_pc = branch_target(pc_plus4, instr[15:0]);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt  = state;
        take_fetch = 1'b0;
        take_exec  = 1'b0;
        case (state)
            IDLE:  state_nxt = FETCH;
            FETCH: begin
                if (imem_ack) begin
                    if (imem_err) begin
                        state_nxt = HALT;
                    end else begin
                        state_nxt  = EXEC;
                        take_fetch = 1'b1;
                    end
                end
            end
            EXEC: begin
                if (exec_done) begin
                    take_exec = 1'b1;
                    state_nxt = pc_fault ? HALT : FETCH;
                end
            end
            HALT:    state_nxt = HALT;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc      <= RESET_PC;
            instr   <= '0;
            retired <= '0;
        end else begin
            if (take_fetch)
                instr <= imem_rdata;
            if (take_exec) begin
                retired <= retired + XLEN'(1);
                if (!pc_fault)
                    pc <= next_pc;
            end
        end
    end

    assign imem_req    = (state == FETCH);
    assign imem_addr   = pc;
    assign instr_valid = (state == EXEC);
    assign halted      = (state == HALT);
    assign op          = instr[31:26];
    assign funct       = instr[5:0];

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed vector table, a jr-fault and fetch-error
// sequence, reset aborts, and a randomized run against a next-PC model.
module tb_fetch_unit;

    logic        clk;
    logic        rst_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        imem_err;
    logic [31:0] instr;
    logic [5:0]  op;
    logic [5:0]  funct;
    logic        instr_valid;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        exec_done;
    logic [1:0]  branch;
    logic        zero;
    logic        jump;
    logic        jump_reg;
    logic [31:0] reg_target;
    logic        halted;
    logic [31:0] retired;

    fetch_unit dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ack   (imem_ack),
        .imem_rdata (imem_rdata),
        .imem_err   (imem_err),
        .instr      (instr),
        .op         (op),
        .funct      (funct),
        .instr_valid(instr_valid),
        .pc         (pc),
        .pc_plus4   (pc_plus4),
        .exec_done  (exec_done),
        .branch     (branch),
        .zero       (zero),
        .jump       (jump),
        .jump_reg   (jump_reg),
        .reg_target (reg_target),
        .halted     (halted),
        .retired    (retired)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int unsigned vectors    = 0;
    int unsigned miscompares = 0;

    logic [31:0] m_pc;
    logic [31:0] m_instr;
    logic [31:0] m_ret;
    logic        m_halt;

    typedef struct {
        logic [31:0] rdata;
        logic [1:0]  br;
        logic        zr;
        logic        jp;
        logic        jrg;
        logic [31:0] tgt;
        logic [31:0] exp_pc;
    } vec_t;

    vec_t tbl[16];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    // Next PC from the architectural rules, using plain integer arithmetic
    function automatic logic [31:0] ref_next(input logic [31:0] cur, input logic [31:0] word,
                                             input logic [1:0] br, input logic zr,
                                             input logic jp, input logic jrg,
                                             input logic [31:0] tgt);
        logic [31:0] p4;
        int          off;
        p4 = cur + 32'd4;
        if (jrg) return tgt;
        if (jp) return (p4 & 32'hF000_0000) | ((word & 32'h03FF_FFFF) << 2);
        if ((br == 2'b01 && zr) || (br == 2'b11 && !zr)) begin
            off = int'($signed(word[15:0]));
            return p4 + 32'(off * 4);
        end
        return p4;
    endfunction

    task automatic drive_noise();
        branch     = 2'($urandom_range(0, 3));
        zero       = 1'($urandom_range(0, 1));
        jump       = 1'($urandom_range(0, 1));
        jump_reg   = 1'($urandom_range(0, 1));
        reg_target = $urandom;
    endtask

    task automatic check_reset_vals(input string tag);
        chk1({tag, "_req"}, imem_req, 1'b0);
        chk1({tag, "_vld"}, instr_valid, 1'b0);
        chk1({tag, "_halt"}, halted, 1'b0);
        chk({tag, "_pc"}, pc, 32'h0);
        chk({tag, "_pc4"}, pc_plus4, 32'h4);
        chk({tag, "_instr"}, instr, 32'h0);
        chk({tag, "_ret"}, retired, 32'h0);
    endtask

    // Called #1 after an edge; leaves the DUT one cycle into FETCH
    task automatic do_reset(input logic hold);
        rst_n     = 1'b0;
        imem_ack  = hold;
        exec_done = hold;
        imem_err  = 1'b0;
        #1;
        for (int i = 0; i < 2; i++) begin
            check_reset_vals("rst");
            @(posedge clk); #1;
        end
        rst_n = 1'b1;
        chk1("idle_req", imem_req, 1'b0);
        chk1("idle_vld", instr_valid, 1'b0);
        @(posedge clk); #1;
        m_pc    = 32'h0;
        m_ret   = 32'h0;
        m_instr = 32'h0;
        m_halt  = 1'b0;
    endtask

    // One full fetch + execute, starting and ending #1 after an edge in FETCH
    task automatic run_instr(input logic [31:0] rdata, input int fwait,
                             input logic [1:0] br, input logic zr, input logic jp,
                             input logic jrg, input logic [31:0] tgt, input int ewait);
        for (int i = 0; i <= fwait; i++) begin
            chk1("fetch_req", imem_req, 1'b1);
            chk("fetch_addr", imem_addr, m_pc);
            chk1("fetch_vld", instr_valid, 1'b0);
            drive_noise();
            exec_done  = 1'($urandom_range(0, 1));
            imem_ack   = (i == fwait);
            imem_rdata = (i == fwait) ? rdata : $urandom;
            imem_err   = (i == fwait) ? 1'b0 : 1'($urandom_range(0, 1));
            @(posedge clk); #1;
        end
        m_instr = rdata;
        for (int i = 0; i <= ewait; i++) begin
            chk1("exec_vld", instr_valid, 1'b1);
            chk1("exec_req", imem_req, 1'b0);
            chk("exec_instr", instr, m_instr);
            chk("exec_op", 32'(op), 32'(m_instr[31:26]));
            chk("exec_funct", 32'(funct), 32'(m_instr[5:0]));
            chk("exec_pc", pc, m_pc);
            chk("exec_pc4", pc_plus4, m_pc + 32'd4);
            chk("exec_ret", retired, m_ret);
            imem_ack   = 1'($urandom_range(0, 1));
            imem_rdata = $urandom;
            imem_err   = 1'($urandom_range(0, 1));
            exec_done  = (i == ewait);
            if (i == ewait) begin
                branch = br; zero = zr; jump = jp; jump_reg = jrg; reg_target = tgt;
            end else begin
                drive_noise();
            end
            @(posedge clk); #1;
        end
        exec_done = 1'b0;
        imem_ack  = 1'b0;
        imem_err  = 1'b0;
        m_ret     = m_ret + 32'd1;
        if (jrg && tgt[1:0] != 2'b00)
            m_halt = 1'b1;
        else
            m_pc = ref_next(m_pc, m_instr, br, zr, jp, jrg, tgt);
    endtask

    task automatic check_halt(input string tag);
        chk1({tag, "_halted"}, halted, 1'b1);
        chk1({tag, "_req"}, imem_req, 1'b0);
        chk1({tag, "_vld"}, instr_valid, 1'b0);
        chk({tag, "_pc"}, pc, m_pc);
        chk({tag, "_ret"}, retired, m_ret);
        chk({tag, "_instr"}, instr, m_instr);
    endtask

    initial begin
        logic [31:0] t;
        logic [1:0]  rbr;
        logic        rjp;
        logic        rjr;

        rst_n = 1'b0; imem_ack = 1'b0; imem_rdata = '0; imem_err = 1'b0;
        exec_done = 1'b0; branch = '0; zero = 1'b0; jump = 1'b0;
        jump_reg = 1'b0; reg_target = '0;

        tbl[0]  = '{32'h2008_0005, 2'b00, 1'b0, 1'b0, 1'b0, 32'h0,         32'h0000_0004};
        tbl[1]  = '{32'h0000_0000, 2'b00, 1'b0, 1'b0, 1'b0, 32'h0,         32'h0000_0008};
        tbl[2]  = '{32'h0000_0000, 2'b00, 1'b0, 1'b0, 1'b1, 32'h10,        32'h0000_0010};
        tbl[3]  = '{32'h1000_FFFF, 2'b01, 1'b1, 1'b0, 1'b0, 32'h0,         32'h0000_0010};
        tbl[4]  = '{32'h1400_0003, 2'b11, 1'b1, 1'b0, 1'b0, 32'h0,         32'h0000_0014};
        tbl[5]  = '{32'h1400_0003, 2'b11, 1'b0, 1'b0, 1'b0, 32'h0,         32'h0000_0024};
        tbl[6]  = '{32'h0000_0005, 2'b10, 1'b1, 1'b0, 1'b0, 32'h0,         32'h0000_0028};
        tbl[7]  = '{32'h0800_0100, 2'b00, 1'b0, 1'b1, 1'b0, 32'h0,         32'h0000_0400};
        tbl[8]  = '{32'h0800_0100, 2'b01, 1'b1, 1'b1, 1'b1, 32'h40,        32'h0000_0040};
        tbl[9]  = '{32'h0000_0000, 2'b00, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC, 32'hFFFF_FFFC};
        tbl[10] = '{32'h0000_0000, 2'b00, 1'b0, 1'b0, 1'b0, 32'h0,         32'h0000_0000};
        tbl[11] = '{32'h1000_FFFE, 2'b01, 1'b1, 1'b0, 1'b0, 32'h0,         32'hFFFF_FFFC};
        tbl[12] = '{32'h0000_0000, 2'b00, 1'b0, 1'b0, 1'b1, 32'hF000_0000, 32'hF000_0000};
        tbl[13] = '{32'h0800_0004, 2'b00, 1'b0, 1'b1, 1'b0, 32'h0,         32'hF000_0010};
        tbl[14] = '{32'h1000_0003, 2'b01, 1'b0, 1'b0, 1'b0, 32'h0,         32'hF000_0014};
        tbl[15] = '{32'h0000_0000, 2'b00, 1'b0, 1'b0, 1'b1, 32'h10,        32'h0000_0010};

        do_reset(1'b0);

        for (int i = 0; i < 16; i++) begin
            run_instr(tbl[i].rdata, i % 3, tbl[i].br, tbl[i].zr, tbl[i].jp,
                      tbl[i].jrg, tbl[i].tgt, i % 2);
            chk("tbl_pc", imem_addr, tbl[i].exp_pc);
            chk("tbl_ret", retired, 32'(i + 1));
        end

        // Misaligned jr from pc 0x10: fault, pc held, instruction still retires
        run_instr(32'h0000_0008, 0, 2'b00, 1'b0, 1'b0, 1'b1, 32'h42, 0);
        for (int i = 0; i < 10; i++) begin
            check_halt("jr_halt");
            imem_ack   = 1'($urandom_range(0, 1));
            exec_done  = 1'($urandom_range(0, 1));
            imem_rdata = $urandom;
            drive_noise();
            @(posedge clk); #1;
        end

        do_reset(1'b0);
        for (int n = 0; n < 150; n++) begin
            t   = $urandom;
            t[1:0] = 2'b00;
            rbr = 2'($urandom_range(0, 3));
            rjp = ($urandom_range(0, 5) == 0);
            rjr = ($urandom_range(0, 5) == 0);
            run_instr($urandom, $urandom_range(0, 3), rbr, 1'($urandom_range(0, 1)),
                      rjp, rjr, t, $urandom_range(0, 3));
        end
        chk("rand_ret", retired, m_ret);

        // Abort mid-fetch with ack held high across the reset
        @(posedge clk); #1;
        chk1("abort_pre_req", imem_req, 1'b1);
        do_reset(1'b1);
        chk1("post_rst_req", imem_req, 1'b1);
        chk("post_rst_addr", imem_addr, 32'h0);
        run_instr(32'h2008_0005, 0, 2'b00, 1'b0, 1'b0, 1'b0, 32'h0, 1);

        // Fetch error: halt with the previous instruction kept
        chk1("err_pre_req", imem_req, 1'b1);
        imem_ack   = 1'b1;
        imem_err   = 1'b1;
        imem_rdata = 32'hDEAD_BEEF;
        @(posedge clk); #1;
        for (int i = 0; i < 4; i++) begin
            check_halt("err_halt");
            imem_err  = 1'($urandom_range(0, 1));
            exec_done = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
